// File: rtl/charmatrix_scroller.sv
// UART text/colour ring buffer scanned column-major into a WS2812B pixel stream; CHARMATRIX_SERPENTINE_EN reverses odd columns.
// First pix_valid 3 cycles after a frame tick; pixels hold stable until pix_ready, rx_ready is always 1 out of reset.
module charmatrix_scroller #(
  parameter int MAX_CHARS  = 8,
  parameter int CHAR_W     = 5,
  parameter int CHAR_H     = 7,
  parameter int FRAME_DIV  = 262144,
  parameter int SCROLL_DIV = 8,
  localparam int AW = $clog2(MAX_CHARS),
  localparam int GW = CHAR_W * CHAR_H
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW:0]   num_chars,
  input  logic          scroll_en,
  input  logic [7:0]    rx_data,
  input  logic          rx_valid,
  output logic          rx_ready,
  input  logic [3:0]    rnd_color,
  output logic [7:0]    rom_addr,
  input  logic [GW-1:0] rom_data,
  output logic          pix_on,
  output logic [3:0]    pix_color,
  output logic          pix_valid,
  input  logic          pix_ready,
  output logic          latch
);

  localparam int GCW = $clog2(CHAR_W + 1);
  localparam int RW  = $clog2(CHAR_H + 1);
  localparam int CCW = $clog2(MAX_CHARS * CHAR_W + 1);
  localparam int FCW = $clog2(FRAME_DIV + 1);
  localparam int SCW = $clog2(SCROLL_DIV + 1);
  localparam int BW  = $clog2(GW + 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_SETTLE = 3'd2;
  localparam logic [2:0] S_SEND   = 3'd3;
  localparam logic [2:0] S_LATCH  = 3'd4;

  logic [2:0]     state;
  logic [7:0]     textbuf  [MAX_CHARS];
  logic [3:0]     colorbuf [MAX_CHARS];
  logic [AW-1:0]  wptr;
  logic [AW-1:0]  slot;
  logic [AW-1:0]  off_slot;
  logic [GCW-1:0] gcol;
  logic [GCW-1:0] off_gcol;
  logic [RW-1:0]  row;
  logic [RW-1:0]  eff_row;
  logic [CCW-1:0] col_cnt;
  logic [CCW-1:0] last_col;
  logic [AW:0]    n_eff;
  logic [AW:0]    n_lat;
  logic [FCW-1:0] fcnt;
  logic [SCW-1:0] scnt;
  logic [3:0]     col_reg;
  logic [BW-1:0]  bit_idx;
  logic [AW-1:0]  slot_nxt;
  logic           frame_tick;
  logic           last_row;
  logic           last_gcol;
  logic           last_slot;
  logic           off_wrap;
  logic           pix_bit;

  always_comb begin
    n_eff = num_chars;
    if (num_chars == '0)
      n_eff = (AW+1)'(1);
    else if (num_chars > (AW+1)'(MAX_CHARS))
      n_eff = (AW+1)'(MAX_CHARS);
  end

  assign frame_tick = (fcnt == FCW'(FRAME_DIV - 1));
  assign last_col   = CCW'(32'(n_lat) * CHAR_W - 1);
  assign last_row   = (row == RW'(CHAR_H - 1));
  assign last_gcol  = (gcol == GCW'(CHAR_W - 1));
  assign last_slot  = ({1'b0, slot} == n_lat - (AW+1)'(1));
  assign slot_nxt   = last_slot ? '0 : slot + 1'b1;

  // Offset wraps at the last virtual column, or if a shrunk num_chars left it out of range.
  assign off_wrap = ({1'b0, off_slot} >= n_lat) ||
                    (({1'b0, off_slot} == n_lat - (AW+1)'(1)) && (off_gcol == GCW'(CHAR_W - 1)));

`ifdef CHARMATRIX_SERPENTINE_EN
  assign eff_row = col_cnt[0] ? RW'(CHAR_H - 1) - row : row;
`else
  assign eff_row = row;
`endif

  assign bit_idx = BW'(gcol) * BW'(CHAR_H) + BW'(eff_row);
  assign pix_bit = rom_data[bit_idx];

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      rx_ready  <= 1'b0;
      pix_valid <= 1'b0;
      pix_on    <= 1'b0;
      pix_color <= '0;
      latch     <= 1'b0;
      rom_addr  <= '0;
      wptr      <= '0;
      slot      <= '0;
      gcol      <= '0;
      row       <= '0;
      col_cnt   <= '0;
      n_lat     <= '0;
      off_slot  <= '0;
      off_gcol  <= '0;
      fcnt      <= '0;
      scnt      <= '0;
      col_reg   <= '0;
      for (int i = 0; i < MAX_CHARS; i++) begin
        textbuf[i]  <= '0;
        colorbuf[i] <= '0;
      end
    end else begin
      rx_ready <= 1'b1;
      fcnt     <= frame_tick ? '0 : fcnt + 1'b1;

      case (state)
        S_IDLE: begin
          if (frame_tick) begin
            n_lat   <= n_eff;
            row     <= '0;
            col_cnt <= '0;
            if ({1'b0, off_slot} >= n_eff) begin
              slot <= '0;
              gcol <= '0;
            end else begin
              slot <= off_slot;
              gcol <= off_gcol;
            end
            state <= S_FETCH;
          end
        end
        S_FETCH: begin
          rom_addr <= textbuf[slot];
          col_reg  <= colorbuf[slot];
          state    <= S_SETTLE;
        end
        S_SETTLE: begin
          pix_on    <= pix_bit;
          pix_color <= col_reg;
          pix_valid <= 1'b1;
          state     <= S_SEND;
        end
        S_SEND: begin
          if (pix_ready) begin
            pix_valid <= 1'b0;
            if (!last_row) begin
              row   <= row + 1'b1;
              state <= S_SETTLE;
            end else begin
              row <= '0;
              if (col_cnt == last_col) begin
                latch <= 1'b1;
                state <= S_LATCH;
              end else begin
                col_cnt <= col_cnt + 1'b1;
                if (last_gcol) begin
                  gcol  <= '0;
                  slot  <= slot_nxt;
                  state <= S_FETCH;
                end else begin
                  gcol  <= gcol + 1'b1;
                  state <= S_SETTLE;
                end
              end
            end
          end
        end
        S_LATCH: begin
          latch <= 1'b0;
          state <= S_IDLE;
          if (!scroll_en) begin
            off_slot <= '0;
            off_gcol <= '0;
            scnt     <= '0;
          end else if (scnt == SCW'(SCROLL_DIV - 1)) begin
            scnt <= '0;
            if (off_wrap) begin
              off_slot <= '0;
              off_gcol <= '0;
            end else if (off_gcol == GCW'(CHAR_W - 1)) begin
              off_gcol <= '0;
              off_slot <= off_slot + 1'b1;
            end else begin
              off_gcol <= off_gcol + 1'b1;
            end
          end else begin
            scnt <= scnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase

      // Placed after the FSM so a form feed overrides a same-cycle scroll step.
      if (rx_valid && rx_ready) begin
        if (rx_data == 8'h0C) begin
          for (int i = 0; i < MAX_CHARS; i++) begin
            textbuf[i]  <= '0;
            colorbuf[i] <= '0;
          end
          wptr     <= '0;
          off_slot <= '0;
          off_gcol <= '0;
        end else begin
          textbuf[wptr]  <= rx_data;
          colorbuf[wptr] <= rnd_color;
          wptr <= ({1'b0, wptr} >= n_eff - (AW+1)'(1)) ? '0 : wptr + 1'b1;
        end
      end
    end
  end

endmodule
